// File: rtl/iq_window_accumulator.sv
// Windowed I/Q demodulator: multiplies each sample by COS/SIN, sums 2^WINDOW_BITS products,
// and emits one scaled pair per window. Define IQ_ACC_ROUND_EN for round-half-up with saturation.
module iq_window_accumulator #(
  parameter int ADC_BITS    = 14,
  parameter int DATA_BITS   = 16,
  parameter int WINDOW_BITS = 10,
  parameter int OUT_BITS    = 32
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CE,
  input  logic                        SYNC,
  input  logic signed [ADC_BITS-1:0]  ADC_IN,
  input  logic signed [DATA_BITS-1:0] SIN,
  input  logic signed [DATA_BITS-1:0] COS,
  output logic signed [OUT_BITS-1:0]  I_OUT,
  output logic signed [OUT_BITS-1:0]  Q_OUT,
  output logic                        OUT_VALID
);
  localparam int PW       = ADC_BITS + DATA_BITS;
  localparam int ACC_BITS = PW + WINDOW_BITS;
  localparam int SHIFT    = ACC_BITS - OUT_BITS;
  localparam logic [WINDOW_BITS-1:0] CNT_MAX = '1;
`ifdef IQ_ACC_ROUND_EN
  localparam int RW  = ACC_BITS + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND     = {{ACC_BITS{1'b0}}, 1'b1} << RSH;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
`endif

  typedef struct packed {
    logic                        vld;
    logic                        sync;
    logic signed [ADC_BITS-1:0]  adc;
    logic signed [DATA_BITS-1:0] sin;
    logic signed [DATA_BITS-1:0] cos;
  } s1_t;

  typedef struct packed {
    logic                 vld;
    logic                 sync;
    logic signed [PW-1:0] p_i;
    logic signed [PW-1:0] p_q;
  } s2_t;

  function automatic logic signed [OUT_BITS-1:0] scale(input logic signed [ACC_BITS-1:0] a);
`ifdef IQ_ACC_ROUND_EN
    logic signed [RW-1:0] r;
    if (SHIFT == 0) return a[OUT_BITS-1:0];
    r = RW'(a) + RND;
    r = r >>> SHIFT;
    // Rounding up can only overflow on the positive side.
    if (r > SAT_MAX) return SAT_MAX[OUT_BITS-1:0];
    return r[OUT_BITS-1:0];
`else
    return OUT_BITS'(a >>> SHIFT);
`endif
  endfunction

  s1_t                        s1_d, s1_q;
  s2_t                        s2_d, s2_q;
  logic signed [ACC_BITS-1:0] acc_i_d, acc_i_q, acc_q_d, acc_q_q;
  logic [WINDOW_BITS-1:0]     cnt_d, cnt_q;
  logic                       done_d, done_q;
  logic signed [OUT_BITS-1:0] i_out_d, i_out_q, q_out_d, q_out_q;
  logic                       out_valid_d, out_valid_q;

  always_comb begin
    s1_d = '{vld: CE, sync: SYNC, adc: ADC_IN, sin: SIN, cos: COS};

    s2_d.vld  = s1_q.vld;
    s2_d.sync = s1_q.vld & s1_q.sync;
    s2_d.p_i  = PW'($signed(s1_q.adc)) * PW'($signed(s1_q.cos));
    s2_d.p_q  = PW'($signed(s1_q.adc)) * PW'($signed(s1_q.sin));

    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (s2_q.vld) begin
      // Sample 0 loads rather than adds, so back-to-back windows need no clear cycle.
      if (s2_q.sync || cnt_q == '0) begin
        acc_i_d = ACC_BITS'($signed(s2_q.p_i));
        acc_q_d = ACC_BITS'($signed(s2_q.p_q));
      end else begin
        acc_i_d = acc_i_q + ACC_BITS'($signed(s2_q.p_i));
        acc_q_d = acc_q_q + ACC_BITS'($signed(s2_q.p_q));
      end
      cnt_d  = s2_q.sync ? WINDOW_BITS'(1) : cnt_q + WINDOW_BITS'(1);
      done_d = !s2_q.sync && (cnt_q == CNT_MAX);
    end

    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    out_valid_d = done_q;
    if (done_q) begin
      i_out_d = scale(acc_i_q);
      q_out_d = scale(acc_q_q);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q        <= '0;
      s2_q        <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign I_OUT     = i_out_q;
  assign Q_OUT     = q_out_q;
  assign OUT_VALID = out_valid_q;
endmodule

// File: tb/tb_iq_window_accumulator.sv
// Directed bench: dut_a has a 4-sample window and no scaling; dut_b is identical but drops two bits.
module tb_iq_window_accumulator;
  logic               clk = 1'b0;
  logic               rst, ce, sync;
  logic signed [13:0] adc;
  logic signed [15:0] sin_v, cos_v;
  logic signed [31:0] i_a, q_a;
  logic signed [29:0] i_b, q_b;
  logic               ov_a, ov_b;

  int n_chk = 0, n_fail = 0;
  int cyc_p = 0, drv_cyc = 0;
  int np_a = 0, np_b = 0, last_a = -1, prev_a = -1;
  int base, c4, c8;

`ifdef IQ_ACC_ROUND_EN
  localparam longint EXP_RP = 1, EXP_RN = 0;
`else
  localparam longint EXP_RP = 0, EXP_RN = -1;
`endif

  iq_window_accumulator #(.ADC_BITS(14), .DATA_BITS(16), .WINDOW_BITS(2), .OUT_BITS(32)) u_dut_a (
    .CLK(clk), .RESET(rst), .CE(ce), .SYNC(sync), .ADC_IN(adc), .SIN(sin_v), .COS(cos_v),
    .I_OUT(i_a), .Q_OUT(q_a), .OUT_VALID(ov_a));

  iq_window_accumulator #(.ADC_BITS(14), .DATA_BITS(16), .WINDOW_BITS(2), .OUT_BITS(30)) u_dut_b (
    .CLK(clk), .RESET(rst), .CE(ce), .SYNC(sync), .ADC_IN(adc), .SIN(sin_v), .COS(cos_v),
    .I_OUT(i_b), .Q_OUT(q_b), .OUT_VALID(ov_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_p <= cyc_p + 1;

  always @(negedge clk) begin
    if (ov_a) begin
      prev_a = last_a;
      last_a = cyc_p;
      np_a++;
    end
    if (ov_b) np_b++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic samp(input logic sy, input int a, input int s, input int c);
    @(negedge clk);
    ce = 1'b1; sync = sy; adc = 14'(a); sin_v = 16'(s); cos_v = 16'(c);
    drv_cyc = cyc_p;
  endtask

  // Invalid cycles carry junk data that must not reach the sums.
  task automatic gap(input int n, input logic sy);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ce = 1'b0; sync = sy; adc = 14'(5000); sin_v = 16'(30000); cos_v = 16'(30000);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; sync = 1'b0; adc = '0; sin_v = '0; cos_v = '0;
    repeat (3) @(negedge clk);
    chk("rst_i_a", i_a, 0);
    chk("rst_q_a", q_a, 0);
    chk("rst_v_a", ov_a, 0);
    chk("rst_i_b", i_b, 0);
    rst = 1'b0;

    // Continuous CE, two windows straight out of reset.
    base = np_a;
    for (int i = 0; i < 8; i++) begin
      samp(1'b0, 100, 0, 32767);
      if (i == 3) c4 = drv_cyc;
    end
    c8 = drv_cyc;
    gap(6, 1'b0);
    chk("t1_npulse", np_a - base, 2);
    chk("t1_first_lat", prev_a, c4 + 4);
    chk("t1_second_lat", last_a, c8 + 4);
    chk("t1_i_a", i_a, 13106800);
    chk("t1_q_a", q_a, 0);
    chk("t1_i_b", i_b, 3276700);

    // Signed extreme product.
    base = np_a;
    samp(1'b1, -8192, -32768, 0);
    for (int i = 0; i < 3; i++) samp(1'b0, -8192, -32768, 0);
    gap(6, 1'b0);
    chk("t2_npulse", np_a - base, 1);
    chk("t2_q_a", q_a, 1073741824);
    chk("t2_i_a", i_a, 0);
    chk("t2_q_b", q_b, 268435456);

    // Scaling: products 1,1,0,0 then -1,-1,0,0.
    samp(1'b1, 1, 0, 1); samp(1'b0, 1, 0, 1); samp(1'b0, 1, 0, 0); samp(1'b0, 1, 0, 0);
    gap(6, 1'b0);
    chk("t3_pos_i_a", i_a, 2);
    chk("t3_pos_i_b", i_b, EXP_RP);
    samp(1'b1, -1, 0, 1); samp(1'b0, -1, 0, 1); samp(1'b0, -1, 0, 0); samp(1'b0, -1, 0, 0);
    gap(6, 1'b0);
    chk("t3_neg_i_a", i_a, -2);
    chk("t3_neg_i_b", i_b, EXP_RN);

    // CE gaps, with a SYNC on an invalid cycle that must be ignored.
    base = np_a;
    samp(1'b1, 10, -1000, 1000); gap(2, 1'b0);
    samp(1'b0, 20, -1000, 1000); gap(1, 1'b1); gap(1, 1'b0);
    samp(1'b0, 30, -1000, 1000); gap(2, 1'b0);
    samp(1'b0, 40, -1000, 1000); c4 = drv_cyc;
    gap(6, 1'b0);
    chk("t4_npulse", np_a - base, 1);
    chk("t4_lat", last_a, c4 + 4);
    chk("t4_i_a", i_a, 100000);
    chk("t4_q_a", q_a, -100000);

    // SYNC on the 3rd sample discards samples 1..2.
    base = np_a;
    samp(1'b1, 1, 2, 1); samp(1'b0, 2, 2, 1);
    samp(1'b1, 3, 2, 1); samp(1'b0, 4, 2, 1); samp(1'b0, 5, 2, 1); samp(1'b0, 6, 2, 1);
    gap(6, 1'b0);
    chk("t5_npulse", np_a - base, 1);
    chk("t5_i_a", i_a, 18);
    chk("t5_q_a", q_a, 36);

    // SYNC on what would have been the last sample of a window.
    base = np_a;
    samp(1'b1, 1, 0, 1); samp(1'b0, 2, 0, 1); samp(1'b0, 3, 0, 1);
    samp(1'b1, 10, 0, 1); samp(1'b0, 20, 0, 1); samp(1'b0, 30, 0, 1); samp(1'b0, 40, 0, 1);
    gap(6, 1'b0);
    chk("t6_npulse", np_a - base, 1);
    chk("t6_i_a", i_a, 100);

    // Reset mid-window.
    base = np_a;
    samp(1'b0, 7, 0, 1); samp(1'b0, 7, 0, 1);
    @(negedge clk);
    ce = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_i_a", i_a, 0);
    chk("t7_rst_v_a", ov_a, 0);
    chk("t7_rst_i_b", i_b, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) samp(1'b0, 3, 0, 1);
    gap(6, 1'b0);
    chk("t7_npulse", np_a - base, 1);
    chk("t7_i_a", i_a, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
